// File: rtl/calc_display_pkg.sv
// calc_pkg: shared encodings for the calculator display stage.
//   - core status encodings (error / busy / ready)
//   - display FSM state type
//   - seven-segment constants (active-low, {dp,g,f,e,d,c,b,a})
//   - err_seg(): error-screen pattern for a digit position
package calc_pkg;

    localparam logic [1:0] ST_ERR   = 2'b00;
    localparam logic [1:0] ST_BUSY  = 2'b01;
    localparam logic [1:0] ST_READY = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_ERROR   = 2'd2
    } disp_state_e;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_ERR_E = 8'h86;
    localparam logic [7:0] SEG_ERR_R = 8'hAF;
    localparam logic [7:0] SEG_ERR_O = 8'hA3;

    // "Erro" occupies digits 3..0; everything above is dark.
    function automatic logic [7:0] err_seg(input int unsigned idx);
        case (idx)
            0:       err_seg = SEG_ERR_O;
            1:       err_seg = SEG_ERR_R;
            2:       err_seg = SEG_ERR_R;
            3:       err_seg = SEG_ERR_E;
            default: err_seg = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/calc_display_if.sv
// calc_display_if: serialised digit stream from the calculator core.
//   status : 2-bit core status (00 error, 01 busy/streaming, 10 ready)
//   data   : BCD digit, lags pos by one clock
//   pos    : digit index
// master = core (drives), slave = display stage (samples).
interface calc_display_if;
    logic [1:0] status;
    logic [3:0] data;
    logic [3:0] pos;

    modport master (output status, output data, output pos);
    modport slave  (input  status, input  data, input  pos);
endinterface

// File: rtl/calc_display_bcd_to_7seg.sv
// bcd_to_7seg: combinational BCD to active-low seven-segment decoder.
//   bcd_i : 4-bit digit value
//   seg_o : {dp,g,f,e,d,c,b,a}, active-low; dp always off.
//           Values 10..15 show a dash.
module bcd_to_7seg
    import calc_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [7:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        case (bcd_i)
            4'd0: seg_o = 8'hC0;
            4'd1: seg_o = 8'hF9;
            4'd2: seg_o = 8'hA4;
            4'd3: seg_o = 8'hB0;
            4'd4: seg_o = 8'h99;
            4'd5: seg_o = 8'h92;
            4'd6: seg_o = 8'h82;
            4'd7: seg_o = 8'hF8;
            4'd8: seg_o = 8'h80;
            4'd9: seg_o = 8'h90;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/calc_display.sv
// calc_display: assembles the core's digit stream into frames and scans
// them onto multiplexed common-anode seven-segment displays.
//   clock, reset : system clock, async active-high reset
//   core         : digit stream (status, data, pos), slave side
//   an           : anode enables, active-low, bit i = display i
//   seg          : segments, active-low {dp,g,f,e,d,c,b,a}
//   frame_valid  : one-cycle pulse after a frame commit
//   err_flag     : high while in the sticky error state
//
// state     | meaning
// ----------+-----------------------------------------------
// S_IDLE    | waiting for the core to start streaming
// S_CAPTURE | writing digits into the shadow buffer
// S_ERROR   | core reported an error; "Erro" shown until reset
module calc_display
    import calc_pkg::*;
#(
    parameter int NUM_DIGITS    = 8,
    parameter int REFRESH_DIV   = 50000,
    parameter int BLANK_LEADING = 1
)(
    input  logic                  clock,
    input  logic                  reset,
    calc_display_if.slave         core,
    output logic [NUM_DIGITS-1:0] an,
    output logic [7:0]            seg,
    output logic                  frame_valid,
    output logic                  err_flag
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(REFRESH_DIV);

    disp_state_e           state_q, state_d;
    logic [1:0]            status_q;
    logic [3:0]            pos_q;
    logic [3:0]            shadow_q [NUM_DIGITS];
    logic [3:0]            shadow_d [NUM_DIGITS];
    logic [3:0]            disp_q   [NUM_DIGITS];
    logic [3:0]            disp_d   [NUM_DIGITS];
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      scan_idx_q, scan_idx_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [7:0]            seg_q, seg_d;
    logic                  fv_q, err_q;

    logic                  commit;
    logic                  wr_en;
    logic [IDX_W-1:0]      wr_idx;
    logic                  tick;
    logic [NUM_DIGITS-1:0] zero_from;
    logic [7:0]            dec_seg;
    logic [7:0]            seg_sel;

    // data arrives one clock after its pos, so the registered pos pairs
    // with the live data bus.
    assign wr_en  = (status_q == ST_BUSY) && (32'(pos_q) < NUM_DIGITS);
    assign wr_idx = pos_q[IDX_W-1:0];

    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (core.status == ST_BUSY)
                    state_d = S_CAPTURE;
                else if (core.status == ST_ERR)
                    state_d = S_ERROR;
            end
            S_CAPTURE: begin
                if (status_q == ST_BUSY && core.status == ST_READY) begin
                    commit  = 1'b1;
                    state_d = S_IDLE;
                end else if (core.status == ST_ERR) begin
                    state_d = S_ERROR;
                end
            end
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // The commit copies shadow_d rather than shadow_q so the last digit,
    // written on the same edge, is part of the frame.
    always_comb begin
        shadow_d = shadow_q;
        if (wr_en)
            shadow_d[wr_idx] = core.data;
        disp_d = disp_q;
        if (commit)
            disp_d = shadow_d;
    end

    // zero_from[i] is set when digits i..top of the committed frame are 0.
    always_comb begin
        logic acc;
        acc       = 1'b1;
        zero_from = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            acc          = acc && (disp_q[i] == 4'd0);
            zero_from[i] = acc;
        end
    end

    bcd_to_7seg u_dec (
        .bcd_i (disp_q[scan_idx_q]),
        .seg_o (dec_seg)
    );

    always_comb begin
        if (state_q == S_ERROR)
            seg_sel = err_seg(32'(scan_idx_q));
        else if (BLANK_LEADING != 0 && scan_idx_q != '0 && zero_from[scan_idx_q])
            seg_sel = SEG_BLANK;
        else
            seg_sel = dec_seg;
    end

    // an and seg load together on the refresh tick so each enabled anode
    // always carries its own digit's pattern.
    assign tick = (cnt_q == CNT_W'(REFRESH_DIV - 1));

    always_comb begin
        cnt_d      = tick ? '0 : cnt_q + 1'b1;
        scan_idx_d = scan_idx_q;
        an_d       = an_q;
        seg_d      = seg_q;
        if (tick) begin
            an_d       = ~(NUM_DIGITS'(1) << scan_idx_q);
            seg_d      = seg_sel;
            scan_idx_d = (32'(scan_idx_q) == NUM_DIGITS - 1) ? '0 : scan_idx_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            status_q   <= ST_READY;
            pos_q      <= 4'd0;
            cnt_q      <= '0;
            scan_idx_q <= '0;
            an_q       <= '1;
            seg_q      <= SEG_BLANK;
            fv_q       <= 1'b0;
            err_q      <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow_q[i] <= 4'd0;
                disp_q[i]   <= 4'd0;
            end
        end else begin
            status_q   <= core.status;
            pos_q      <= core.pos;
            cnt_q      <= cnt_d;
            scan_idx_q <= scan_idx_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            fv_q       <= commit;
            err_q      <= (state_d == S_ERROR);
            shadow_q   <= shadow_d;
            disp_q     <= disp_d;
        end
    end

    assign an          = an_q;
    assign seg         = seg_q;
    assign frame_valid = fv_q;
    assign err_flag    = err_q;

endmodule

// File: tb/tb_calc_display.sv
// Directed bench for calc_display: two instances share one stream, one
// with leading-zero blanking and one without.
module tb_calc_display;
    import calc_pkg::*;

    localparam int DIV = 4;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    calc_display_if bus ();

    logic [7:0] an_b, seg_b, an_n, seg_n;
    logic       fv_b, err_b, fv_n, err_n;

    calc_display #(.NUM_DIGITS(8), .REFRESH_DIV(DIV), .BLANK_LEADING(1)) dut_b (
        .clock (clock), .reset (reset), .core (bus),
        .an (an_b), .seg (seg_b), .frame_valid (fv_b), .err_flag (err_b)
    );

    calc_display #(.NUM_DIGITS(8), .REFRESH_DIV(DIV), .BLANK_LEADING(0)) dut_n (
        .clock (clock), .reset (reset), .core (bus),
        .an (an_n), .seg (seg_n), .frame_valid (fv_n), .err_flag (err_n)
    );

    int tests  = 0;
    int failed = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    // Sync to digit 0 being enabled, then check every digit of one scan.
    // exp holds digit i in bits [8*i +: 8].
    task automatic scan(input bit sel, input logic [63:0] exp, input string tag);
        int w;
        logic [7:0] ea;
        w = 0;
        while (((sel ? an_n : an_b) !== 8'hFE) && w < 200) begin
            @(negedge clock);
            w++;
        end
        chk({tag, "_sync"}, sel ? an_n : an_b, 8'hFE);
        for (int i = 0; i < 8; i++) begin
            ea = ~(8'h01 << i);
            chk({tag, "_an"},  sel ? an_n  : an_b,  ea);
            chk({tag, "_seg"}, sel ? seg_n : seg_b, exp[8*i +: 8]);
            repeat (DIV) @(negedge clock);
        end
    endtask

    // Stream n positions (pv nibbles) with data (dv nibbles) one clock late,
    // finishing with status fin alongside the last data digit.
    task automatic send(input int n, input logic [63:0] pv, input logic [63:0] dv,
                        input logic [1:0] fin);
        @(negedge clock);
        bus.status = ST_BUSY;
        bus.pos    = pv[3:0];
        bus.data   = 4'h0;
        for (int k = 1; k < n; k++) begin
            @(negedge clock);
            bus.pos  = pv[4*k +: 4];
            bus.data = dv[4*(k-1) +: 4];
        end
        @(negedge clock);
        bus.status = fin;
        bus.data   = dv[4*(n-1) +: 4];
        bus.pos    = 4'h0;
    endtask

    task automatic count_fv(input int cycles, input string tag);
        int c;
        c = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            if (fv_b) c++;
        end
        chk(tag, 8'(c), 8'd0);
    endtask

    task automatic commit_pulse(input string tag);
        @(negedge clock);
        chk({tag, "_fv_hi"}, {7'd0, fv_b}, 8'd1);
        chk({tag, "_fvn_hi"}, {7'd0, fv_n}, 8'd1);
        @(negedge clock);
        chk({tag, "_fv_lo"}, {7'd0, fv_b}, 8'd0);
        count_fv(10, {tag, "_fv_once"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        bus.status = ST_READY;
        bus.pos    = 4'h0;
        bus.data   = 4'h0;
        #1;
        chk("rst_an",  an_b,  8'hFF);
        chk("rst_seg", seg_b, 8'hFF);
        chk("rst_fv",  {7'd0, fv_b},  8'd0);
        chk("rst_err", {7'd0, err_b}, 8'd0);

        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (DIV - 1) @(negedge clock);
        chk("first_tick_pre", an_b, 8'hFF);
        @(negedge clock);
        chk("first_tick_an",  an_b,  8'hFE);
        chk("first_tick_seg", seg_b, 8'hC0);

        scan(1'b0, 64'hFFFFFFFF_FFFFFFC0, "idle_b");
        scan(1'b1, 64'hC0C0C0C0_C0C0C0C0, "idle_n");

        // 1234: pos 0..7, digits 4,3,2,1,0,0,0,0
        send(8, 64'h76543210, 64'h00001234, ST_READY);
        commit_pulse("f1234");
        scan(1'b0, 64'hFFFFFFFF_F9A4B099, "f1234_b");
        scan(1'b1, 64'hC0C0C0C0_F9A4B099, "f1234_n");
        chk("f1234_err", {7'd0, err_b}, 8'd0);

        // pos 0,1,2,9,3..7 with 7,6,12,5,8,0,0,0,0 ; pos 9 must be dropped
        send(9, 64'h765439210, 64'h000085C67, ST_READY);
        commit_pulse("range");
        scan(1'b0, 64'hFFFFFFFF_80BF82F8, "range_b");
        scan(1'b1, 64'hC0C0C0C0_80BF82F8, "range_n");

        // Three positions then an error: no commit, sticky error screen
        send(3, 64'h210, 64'h321, ST_ERR);
        @(negedge clock);
        chk("err_flag_b", {7'd0, err_b}, 8'd1);
        chk("err_flag_n", {7'd0, err_n}, 8'd1);
        count_fv(10, "err_no_fv");
        bus.status = ST_READY;
        scan(1'b0, 64'hFFFFFFFF_86AFAFA3, "err_b");
        scan(1'b1, 64'hFFFFFFFF_86AFAFA3, "err_n");
        chk("err_sticky", {7'd0, err_b}, 8'd1);

        reset = 1'b1;
        #1;
        chk("rst2_err", {7'd0, err_b}, 8'd0);
        @(negedge clock);
        reset = 1'b0;

        send(8, 64'h76543210, 64'h00001234, ST_READY);
        commit_pulse("again");
        repeat (40) @(negedge clock);
        chk("pre_mid_an_active", {7'd0, an_b == 8'hFF}, 8'd0);

        // Reset asserted between edges while the core is at pos 4
        @(negedge clock);
        bus.status = ST_BUSY;
        bus.pos    = 4'h0;
        bus.data   = 4'h0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clock);
            bus.pos  = 4'(k);
            bus.data = 4'(5 + k);
        end
        #2;
        reset = 1'b1;
        #1;
        chk("mid_an",  an_b,  8'hFF);
        chk("mid_seg", seg_b, 8'hFF);
        chk("mid_fv",  {7'd0, fv_b},  8'd0);
        chk("mid_err", {7'd0, err_b}, 8'd0);
        bus.status = ST_READY;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (DIV - 1) @(negedge clock);
        chk("mid_blank", an_b, 8'hFF);
        count_fv(40, "mid_no_fv");
        scan(1'b0, 64'hFFFFFFFF_FFFFFFC0, "mid_b");
        scan(1'b1, 64'hC0C0C0C0_C0C0C0C0, "mid_n");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
